// File: rtl/mem_issue_queue_pkg.sv
// rtl/mem_issue_queue_pkg.sv - shared widths and op codes for the memory issue queue
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef DATA_WIDTH_MEM_OP
`define DATA_WIDTH_MEM_OP 3
`endif
`ifndef ROB_DEPTH
`define ROB_DEPTH 32
`endif
`ifndef MEM_OP_LB
`define MEM_OP_LB 3'd0
`define MEM_OP_LH 3'd1
`define MEM_OP_LW 3'd2
`define MEM_OP_SB 3'd3
`define MEM_OP_SH 3'd4
`define MEM_OP_SW 3'd5
`endif

package mem_issue_queue_pkg;
   localparam int WORD_W    = `WORD_WIDTH;
   localparam int OP_W      = `DATA_WIDTH_MEM_OP;
   localparam int DEF_TAG_W = $clog2(`ROB_DEPTH);
endpackage

// File: rtl/mem_iq_wakeup.sv
// rtl/mem_iq_wakeup.sv - per-source tag compare against two writeback ports, wb0 first
module mem_iq_wakeup
   import mem_issue_queue_pkg::*;
#(
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic              ready,
   input  logic [TAG_W-1:0]  tag,
   input  logic [WORD_W-1:0] value,
   input  logic              wb0_valid,
   input  logic [TAG_W-1:0]  wb0_tag,
   input  logic [WORD_W-1:0] wb0_value,
   input  logic              wb1_valid,
   input  logic [TAG_W-1:0]  wb1_tag,
   input  logic [WORD_W-1:0] wb1_value,
   output logic              ready_nxt,
   output logic [WORD_W-1:0] value_nxt
);
   always_comb begin
      ready_nxt = ready;
      value_nxt = value;
      if (!ready) begin
         if (wb0_valid && (wb0_tag == tag)) begin
            ready_nxt = 1'b1;
            value_nxt = wb0_value;
         end else if (wb1_valid && (wb1_tag == tag)) begin
            ready_nxt = 1'b1;
            value_nxt = wb1_value;
         end
      end
   end
endmodule

// File: rtl/mem_issue_queue.sv
// rtl/mem_issue_queue.sv - in-order load/store issue queue with operand capture from two wb ports
module mem_issue_queue
   import mem_issue_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              dispatch_en,
   input  logic [OP_W-1:0]   dispatch_op,
   input  logic [WORD_W-1:0] dispatch_imm,
   input  logic              dispatch_rs1_ready,
   input  logic [TAG_W-1:0]  dispatch_rs1_tag,
   input  logic [WORD_W-1:0] dispatch_rs1_value,
   input  logic              dispatch_rs2_ready,
   input  logic [TAG_W-1:0]  dispatch_rs2_tag,
   input  logic [WORD_W-1:0] dispatch_rs2_value,
   input  logic [TAG_W-1:0]  dispatch_Pdst,
   output logic              queue_full,
   output logic              queue_empty,
   input  logic              wb0_valid,
   input  logic [TAG_W-1:0]  wb0_tag,
   input  logic [WORD_W-1:0] wb0_value,
   input  logic              wb1_valid,
   input  logic [TAG_W-1:0]  wb1_tag,
   input  logic [WORD_W-1:0] wb1_value,
   input  logic              mem_ready,
   output logic              mem_issue_en,
   output logic [OP_W-1:0]   mem_issue_queue_op,
   output logic [WORD_W-1:0] mem_issue_queue_imm,
   output logic [WORD_W-1:0] mem_issue_queue_rs1_value,
   output logic [WORD_W-1:0] mem_issue_queue_rs2_value,
   output logic [TAG_W-1:0]  mem_issue_queue_Pdst
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic              valid_q   [DEPTH], valid_d   [DEPTH];
   logic [OP_W-1:0]   op_q      [DEPTH], op_d      [DEPTH];
   logic [WORD_W-1:0] imm_q     [DEPTH], imm_d     [DEPTH];
   logic [TAG_W-1:0]  pdst_q    [DEPTH], pdst_d    [DEPTH];
   logic              rs1_rdy_q [DEPTH], rs1_rdy_d [DEPTH], rs1_rdy_w [DEPTH];
   logic [TAG_W-1:0]  rs1_tag_q [DEPTH], rs1_tag_d [DEPTH];
   logic [WORD_W-1:0] rs1_val_q [DEPTH], rs1_val_d [DEPTH], rs1_val_w [DEPTH];
   logic              rs2_rdy_q [DEPTH], rs2_rdy_d [DEPTH], rs2_rdy_w [DEPTH];
   logic [TAG_W-1:0]  rs2_tag_q [DEPTH], rs2_tag_d [DEPTH];
   logic [WORD_W-1:0] rs2_val_q [DEPTH], rs2_val_d [DEPTH], rs2_val_w [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              disp_rs1_rdy, disp_rs2_rdy;
   logic [WORD_W-1:0] disp_rs1_val, disp_rs2_val;
   logic              dispatch_ok;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      mem_iq_wakeup #(.TAG_W(TAG_W)) u_wk_rs1 (
         .ready(rs1_rdy_q[i]), .tag(rs1_tag_q[i]), .value(rs1_val_q[i]),
         .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_value(wb0_value),
         .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_value(wb1_value),
         .ready_nxt(rs1_rdy_w[i]), .value_nxt(rs1_val_w[i]));
      mem_iq_wakeup #(.TAG_W(TAG_W)) u_wk_rs2 (
         .ready(rs2_rdy_q[i]), .tag(rs2_tag_q[i]), .value(rs2_val_q[i]),
         .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_value(wb0_value),
         .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_value(wb1_value),
         .ready_nxt(rs2_rdy_w[i]), .value_nxt(rs2_val_w[i]));
   end

   // Same-cycle bypass so a dispatched operand never misses a broadcast
   mem_iq_wakeup #(.TAG_W(TAG_W)) u_byp_rs1 (
      .ready(dispatch_rs1_ready), .tag(dispatch_rs1_tag), .value(dispatch_rs1_value),
      .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_value(wb0_value),
      .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_value(wb1_value),
      .ready_nxt(disp_rs1_rdy), .value_nxt(disp_rs1_val));
   mem_iq_wakeup #(.TAG_W(TAG_W)) u_byp_rs2 (
      .ready(dispatch_rs2_ready), .tag(dispatch_rs2_tag), .value(dispatch_rs2_value),
      .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_value(wb0_value),
      .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_value(wb1_value),
      .ready_nxt(disp_rs2_rdy), .value_nxt(disp_rs2_val));

   assign queue_full   = (count_q == FULL_CNT);
   assign queue_empty  = (count_q == '0);
   assign dispatch_ok  = dispatch_en && !queue_full && !flush;
   assign mem_issue_en = valid_q[head_q] && rs1_rdy_q[head_q] && rs2_rdy_q[head_q]
                         && mem_ready && !flush;

   assign mem_issue_queue_op        = valid_q[head_q] ? op_q[head_q]      : '0;
   assign mem_issue_queue_imm       = valid_q[head_q] ? imm_q[head_q]     : '0;
   assign mem_issue_queue_rs1_value = valid_q[head_q] ? rs1_val_q[head_q] : '0;
   assign mem_issue_queue_rs2_value = valid_q[head_q] ? rs2_val_q[head_q] : '0;
   assign mem_issue_queue_Pdst      = valid_q[head_q] ? pdst_q[head_q]    : '0;

   always_comb begin
      valid_d   = valid_q;
      op_d      = op_q;
      imm_d     = imm_q;
      pdst_d    = pdst_q;
      rs1_rdy_d = rs1_rdy_q;
      rs1_tag_d = rs1_tag_q;
      rs1_val_d = rs1_val_q;
      rs2_rdy_d = rs2_rdy_q;
      rs2_tag_d = rs2_tag_q;
      rs2_val_d = rs2_val_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) begin
            rs1_rdy_d[i] = rs1_rdy_w[i];
            rs1_val_d[i] = rs1_val_w[i];
            rs2_rdy_d[i] = rs2_rdy_w[i];
            rs2_val_d[i] = rs2_val_w[i];
         end
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) valid_d[i] = 1'b0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (mem_issue_en) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
         end
         if (dispatch_ok) begin
            valid_d[tail_q]   = 1'b1;
            op_d[tail_q]      = dispatch_op;
            imm_d[tail_q]     = dispatch_imm;
            pdst_d[tail_q]    = dispatch_Pdst;
            rs1_rdy_d[tail_q] = disp_rs1_rdy;
            rs1_tag_d[tail_q] = dispatch_rs1_tag;
            rs1_val_d[tail_q] = disp_rs1_val;
            rs2_rdy_d[tail_q] = disp_rs2_rdy;
            rs2_tag_d[tail_q] = dispatch_rs2_tag;
            rs2_val_d[tail_q] = disp_rs2_val;
            tail_d            = tail_q + 1'b1;
         end
         case ({dispatch_ok, mem_issue_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= '{default: '0};
         op_q      <= '{default: '0};
         imm_q     <= '{default: '0};
         pdst_q    <= '{default: '0};
         rs1_rdy_q <= '{default: '0};
         rs1_tag_q <= '{default: '0};
         rs1_val_q <= '{default: '0};
         rs2_rdy_q <= '{default: '0};
         rs2_tag_q <= '{default: '0};
         rs2_val_q <= '{default: '0};
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         valid_q   <= valid_d;
         op_q      <= op_d;
         imm_q     <= imm_d;
         pdst_q    <= pdst_d;
         rs1_rdy_q <= rs1_rdy_d;
         rs1_tag_q <= rs1_tag_d;
         rs1_val_q <= rs1_val_d;
         rs2_rdy_q <= rs2_rdy_d;
         rs2_tag_q <= rs2_tag_d;
         rs2_val_q <= rs2_val_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end
endmodule

// File: tb/tb_mem_issue_queue.sv
// tb/tb_mem_issue_queue.sv - directed self-checking bench for mem_issue_queue
module tb_mem_issue_queue;
   localparam int TAG_W = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              dispatch_en;
   logic [2:0]        dispatch_op;
   logic [31:0]       dispatch_imm;
   logic              dispatch_rs1_ready;
   logic [TAG_W-1:0]  dispatch_rs1_tag;
   logic [31:0]       dispatch_rs1_value;
   logic              dispatch_rs2_ready;
   logic [TAG_W-1:0]  dispatch_rs2_tag;
   logic [31:0]       dispatch_rs2_value;
   logic [TAG_W-1:0]  dispatch_Pdst;
   logic              queue_full, queue_empty;
   logic              wb0_valid, wb1_valid;
   logic [TAG_W-1:0]  wb0_tag, wb1_tag;
   logic [31:0]       wb0_value, wb1_value;
   logic              mem_ready;
   logic              mem_issue_en;
   logic [2:0]        mem_issue_queue_op;
   logic [31:0]       mem_issue_queue_imm;
   logic [31:0]       mem_issue_queue_rs1_value;
   logic [31:0]       mem_issue_queue_rs2_value;
   logic [TAG_W-1:0]  mem_issue_queue_Pdst;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_issue_queue #(.DEPTH(4), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .dispatch_en(dispatch_en), .dispatch_op(dispatch_op), .dispatch_imm(dispatch_imm),
      .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs1_tag(dispatch_rs1_tag),
      .dispatch_rs1_value(dispatch_rs1_value),
      .dispatch_rs2_ready(dispatch_rs2_ready), .dispatch_rs2_tag(dispatch_rs2_tag),
      .dispatch_rs2_value(dispatch_rs2_value), .dispatch_Pdst(dispatch_Pdst),
      .queue_full(queue_full), .queue_empty(queue_empty),
      .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_value(wb0_value),
      .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_value(wb1_value),
      .mem_ready(mem_ready), .mem_issue_en(mem_issue_en),
      .mem_issue_queue_op(mem_issue_queue_op), .mem_issue_queue_imm(mem_issue_queue_imm),
      .mem_issue_queue_rs1_value(mem_issue_queue_rs1_value),
      .mem_issue_queue_rs2_value(mem_issue_queue_rs2_value),
      .mem_issue_queue_Pdst(mem_issue_queue_Pdst));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic disp(input logic [2:0] op, input logic [31:0] imm,
                       input logic r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                       input logic r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2,
                       input logic [TAG_W-1:0] pdst);
      dispatch_en = 1'b1; dispatch_op = op; dispatch_imm = imm;
      dispatch_rs1_ready = r1; dispatch_rs1_tag = t1; dispatch_rs1_value = v1;
      dispatch_rs2_ready = r2; dispatch_rs2_tag = t2; dispatch_rs2_value = v2;
      dispatch_Pdst = pdst;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; dispatch_en = 1'b0; dispatch_op = '0; dispatch_imm = '0;
      dispatch_rs1_ready = 1'b0; dispatch_rs1_tag = '0; dispatch_rs1_value = '0;
      dispatch_rs2_ready = 1'b0; dispatch_rs2_tag = '0; dispatch_rs2_value = '0;
      dispatch_Pdst = '0; wb0_valid = 1'b0; wb0_tag = '0; wb0_value = '0;
      wb1_valid = 1'b0; wb1_tag = '0; wb1_value = '0; mem_ready = 1'b0;
      tick(); tick();
      chk("rst_full", 32'(queue_full), 32'd0);
      chk("rst_empty", 32'(queue_empty), 32'd1);
      chk("rst_issue_en", 32'(mem_issue_en), 32'd0);
      chk("rst_imm", mem_issue_queue_imm, 32'd0);
      chk("rst_pdst", 32'(mem_issue_queue_Pdst), 32'd0);
      rst_n = 1'b1;
      tick();

      // Simple LW, one-cycle latency to issue
      mem_ready = 1'b1;
      disp(3'd2, 32'd4, 1'b1, 5'd0, 32'h1000, 1'b1, 5'd0, 32'h0, 5'd3);
      settle();
      chk("lw_no_issue_empty", 32'(mem_issue_en), 32'd0);
      tick();
      dispatch_en = 1'b0;
      settle();
      chk("lw_issue_en", 32'(mem_issue_en), 32'd1);
      chk("lw_op", 32'(mem_issue_queue_op), 32'd2);
      chk("lw_rs1", mem_issue_queue_rs1_value, 32'h1000);
      chk("lw_imm", mem_issue_queue_imm, 32'd4);
      chk("lw_pdst", 32'(mem_issue_queue_Pdst), 32'd3);
      tick();
      chk("lw_empty_after", 32'(queue_empty), 32'd1);
      chk("lw_issue_after", 32'(mem_issue_en), 32'd0);

      // SW with rs2 woken by wb0
      disp(3'd5, 32'd8, 1'b1, 5'd0, 32'h2000, 1'b0, 5'd5, 32'h0, 5'd6);
      tick();
      dispatch_en = 1'b0;
      settle();
      chk("sw_wait", 32'(mem_issue_en), 32'd0);
      wb0_valid = 1'b1; wb0_tag = 5'd5; wb0_value = 32'hDEADBEEF;
      settle();
      chk("sw_no_wake_bypass", 32'(mem_issue_en), 32'd0);
      tick();
      wb0_valid = 1'b0;
      settle();
      chk("sw_issue_en", 32'(mem_issue_en), 32'd1);
      chk("sw_rs2", mem_issue_queue_rs2_value, 32'hDEADBEEF);
      chk("sw_pdst", 32'(mem_issue_queue_Pdst), 32'd6);
      tick();

      // Fill across the pointer wrap, drop the fifth dispatch
      mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         disp(3'd2, 32'(k), 1'b1, 5'd0, 32'h100 + 32'(k), 1'b1, 5'd0, 32'h0, 5'(10 + k));
         tick();
      end
      chk("fill_full", 32'(queue_full), 32'd1);
      disp(3'd2, 32'd0, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 5'd14);
      tick();
      dispatch_en = 1'b0;
      chk("fill_still_full", 32'(queue_full), 32'd1);
      mem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("drain_en", 32'(mem_issue_en), 32'd1);
         chk("drain_pdst", 32'(mem_issue_queue_Pdst), 32'(10 + k));
         tick();
      end
      chk("drain_empty", 32'(queue_empty), 32'd1);
      chk("drain_no_fifth", 32'(mem_issue_en), 32'd0);

      // In-order blocking: head waits on tag 7 from wb1
      disp(3'd0, 32'd0, 1'b0, 5'd7, 32'h0, 1'b1, 5'd0, 32'h0, 5'd20);
      tick();
      disp(3'd0, 32'd0, 1'b1, 5'd0, 32'h4000, 1'b1, 5'd0, 32'h0, 5'd21);
      tick();
      dispatch_en = 1'b0;
      settle();
      chk("block_en0", 32'(mem_issue_en), 32'd0);
      chk("block_head", 32'(mem_issue_queue_Pdst), 32'd20);
      tick();
      chk("block_en1", 32'(mem_issue_en), 32'd0);
      wb1_valid = 1'b1; wb1_tag = 5'd7; wb1_value = 32'h3000;
      settle();
      chk("block_en2", 32'(mem_issue_en), 32'd0);
      tick();
      wb1_valid = 1'b0;
      settle();
      chk("unblock_en", 32'(mem_issue_en), 32'd1);
      chk("unblock_pdst", 32'(mem_issue_queue_Pdst), 32'd20);
      chk("unblock_rs1", mem_issue_queue_rs1_value, 32'h3000);
      tick();
      chk("second_en", 32'(mem_issue_en), 32'd1);
      chk("second_pdst", 32'(mem_issue_queue_Pdst), 32'd21);
      tick();
      chk("block_empty", 32'(queue_empty), 32'd1);

      // Dispatch bypass with both ports matching: wb0 wins
      mem_ready = 1'b0;
      disp(3'd1, 32'd0, 1'b0, 5'd9, 32'h0, 1'b1, 5'd0, 32'h0, 5'd25);
      wb0_valid = 1'b1; wb0_tag = 5'd9; wb0_value = 32'h11;
      wb1_valid = 1'b1; wb1_tag = 5'd9; wb1_value = 32'h22;
      tick();
      dispatch_en = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0;
      settle();
      chk("byp_held", 32'(mem_issue_en), 32'd0);
      chk("byp_value", mem_issue_queue_rs1_value, 32'h11);
      mem_ready = 1'b1;
      settle();
      chk("byp_issue", 32'(mem_issue_en), 32'd1);
      tick();

      // Flush with three entries and an issuable head
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         disp(3'd2, 32'd0, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 5'(30 + k));
         tick();
      end
      mem_ready = 1'b1; flush = 1'b1;
      disp(3'd2, 32'd0, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 5'd33);
      settle();
      chk("flush_no_issue", 32'(mem_issue_en), 32'd0);
      tick();
      flush = 1'b0; dispatch_en = 1'b0;
      settle();
      chk("flush_empty", 32'(queue_empty), 32'd1);
      chk("flush_head", 32'(dut.head_q), 32'd0);
      chk("flush_tail", 32'(dut.tail_q), 32'd0);
      chk("flush_idle", 32'(mem_issue_en), 32'd0);
      disp(3'd2, 32'd12, 1'b1, 5'd0, 32'h5000, 1'b1, 5'd0, 32'h0, 5'd4);
      tick();
      dispatch_en = 1'b0;
      settle();
      chk("post_flush_en", 32'(mem_issue_en), 32'd1);
      chk("post_flush_pdst", 32'(mem_issue_queue_Pdst), 32'd4);
      chk("post_flush_imm", mem_issue_queue_imm, 32'd12);
      tick();

      // Asynchronous reset mid-operation
      mem_ready = 1'b0;
      disp(3'd2, 32'd0, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 5'd8);
      tick();
      dispatch_en = 1'b0;
      chk("pre_rst_nonempty", 32'(queue_empty), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_empty", 32'(queue_empty), 32'd1);
      chk("async_rst_pdst", 32'(mem_issue_queue_Pdst), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_issue_queue.md
Name: mem_issue_queue

Overview:
- In-order issue queue for load/store micro-ops, directly upstream of the memory controller.
- Accepts dispatched memory ops with renamed source operands and captures operand values from two writeback broadcast ports.
- Issues the oldest op to the memory controller when its operands are ready and the controller reports ready.
- Strict in-order issue: no load/store reordering, so no disambiguation logic is required.

Parameters:
- DEPTH, 4: number of queue entries; power of two, at least 2.
- TAG_W, $clog2(`ROB_DEPTH): width of ROB tags (Pdst and source tags).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  pipeline flush; discards all entries
- dispatch_en  in  1  dispatch request
- dispatch_op  in  `DATA_WIDTH_MEM_OP  memory op code
- dispatch_imm  in  `WORD_WIDTH  address offset
- dispatch_rs1_ready  in  1  rs1 value already valid
- dispatch_rs1_tag  in  TAG_W  producer tag of rs1
- dispatch_rs1_value  in  `WORD_WIDTH  rs1 value, used when ready
- dispatch_rs2_ready  in  1  rs2 value already valid; dispatcher drives 1 for loads
- dispatch_rs2_tag  in  TAG_W  producer tag of rs2
- dispatch_rs2_value  in  `WORD_WIDTH  store data, used when ready
- dispatch_Pdst  in  TAG_W  ROB destination of this op
- queue_full  out  1  no free entry; dispatch is refused
- queue_empty  out  1  no valid entry
- wb0_valid  in  1  ALU writeback broadcast valid
- wb0_tag  in  TAG_W  ALU writeback tag
- wb0_value  in  `WORD_WIDTH  ALU writeback value
- wb1_valid  in  1  load writeback broadcast valid (from load_data_valid)
- wb1_tag  in  TAG_W  load writeback tag (from mem_dst_Paddr)
- wb1_value  in  `WORD_WIDTH  load writeback value (from load_data)
- mem_ready  in  1  memory controller can accept an op this cycle
- mem_issue_en  out  1  issue strobe
- mem_issue_queue_op  out  `DATA_WIDTH_MEM_OP  op of the issued entry
- mem_issue_queue_imm  out  `WORD_WIDTH  imm of the issued entry
- mem_issue_queue_rs1_value  out  `WORD_WIDTH  base address value
- mem_issue_queue_rs2_value  out  `WORD_WIDTH  store data
- mem_issue_queue_Pdst  out  TAG_W  ROB destination

Behaviour:
- Storage:
  - Circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Count register of $clog2(DEPTH)+1 bits.
  - Per-entry fields: valid, op, imm, Pdst, and for each source a ready bit, tag and value.
- Reset:
  - All valid and ready bits clear; head, tail and count are 0.
  - queue_full=0, queue_empty=1, mem_issue_en=0.
  - All mem_issue_queue_* outputs are 0.
- Full/empty flags:
  - queue_full = (count==DEPTH); queue_empty = (count==0).
  - Both derive from the registered count only.
- Dispatch:
  - Accepted when dispatch_en && !queue_full && !flush; writes the tail entry and tail advances at the clock edge.
  - A dispatch while full is dropped silently, and no state changes.
  - This holds even if an issue happens in the same cycle (no same-cycle slot reuse).
- Dispatch-time bypass:
  - If a source arrives not ready and a wb port broadcasts its tag in the same cycle, the entry captures the wb value with ready=1.
  - wb0 has priority over wb1 on a double match.
- Wakeup:
  - Every cycle, each valid entry with source ready=0 compares its tag against both wb ports.
  - On a match, the entry latches the value and sets ready at the edge; wb0 wins if both match.
  - A woken operand becomes visible to issue one cycle later; there is no wakeup-to-issue bypass.
- Issue (combinational from head registers):
  - mem_issue_en = head.valid && head.rs1_ready && head.rs2_ready && mem_ready && !flush.
  - The mem_issue_queue_* outputs show the head fields whenever head.valid; otherwise they are 0.
  - When mem_issue_en=1, head is invalidated and advances at the edge (one-cycle latency, head to memory controller).
- Ordering: a not-ready head blocks all younger entries.
- Simultaneous dispatch and issue: count is unchanged, and both pointers advance.
- Wrap-around: pointer DEPTH-1 advances to 0; full and empty are distinguished by count, never by pointer compare.
- Flush:
  - mem_issue_en is forced 0 in the same cycle.
  - At the edge, all valid bits clear and head, tail and count return to 0.
  - Any dispatch in that cycle is discarded.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to the reset values.

Decomposition:
- Shared package/defines: `DATA_WIDTH_MEM_OP, `MEM_OP_* codes, `WORD_WIDTH, `ROB_DEPTH. These already exist; the block adds none.
- One natural sub-module: mem_iq_wakeup, the per-source tag compare/priority mux (tag, ready, wb0/wb1 in; next ready and value out).
  - Instantiated 2×DEPTH times for the entries, plus 2 for dispatch bypass.

Test Plan:
- Reset, then dispatch LW with rs1 ready=0x1000, imm=4, rs2_ready=1, Pdst=3, mem_ready=1 -> next cycle mem_issue_en=1, rs1_value=0x1000, imm=4, Pdst=3; afterwards queue_empty=1.
- Dispatch SW with rs2 not ready (tag 5); one cycle later wb0_valid, tag 5, value 0xDEADBEEF -> issue occurs exactly one cycle after the wakeup edge, with rs2_value=0xDEADBEEF.
- Fill 4 entries with mem_ready=0 -> queue_full=1 and a 5th dispatch is dropped. Then raise mem_ready -> 4 issues in dispatch order across the wrap of tail 3→0, with Pdst sequence preserved.
- Head waits on tag 7 while the second entry is ready -> no issue until wb1 broadcasts tag 7 (in-order blocking). Then both issue on consecutive cycles.
- Dispatch with wb0 and wb1 both broadcasting the source tag (0x11 vs 0x22) in the same cycle -> captured value is 0x11.
- With 3 valid entries, assert flush while head is issuable -> mem_issue_en=0 that cycle; the next cycle has queue_empty=1 and head=tail=0, and a new dispatch issues normally.
